// File: rtl/mux_8x1_rr_arbiter_pkg.sv
// Shared definitions for the round-robin 8:1 mux arbiter.
package mux_8x1_rr_arbiter_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mux_8x1_rr_arbiter_pick.sv
// Rotating-priority pick: first set request bit starting at ptr, wrapping mod 8.
module rr_priority_pick
  import mux_8x1_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   index
);

  // Scan from the farthest offset down so the nearest set bit to ptr wins last.
  always_comb begin
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/mux_8x1_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 datapath mux between eight packet streams.
module mux_8x1_rr_arbiter
  import mux_8x1_rr_arbiter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         last,
  input  logic [NUM_REQ*WIDTH-1:0]   in_data,
  output logic [NUM_REQ-1:0]         in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [NUM_REQ-1:0]         grant,
  output logic [SEL_W-1:0]           select,
  output logic                       en
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [SEL_W-1:0]   select_nxt;
  logic               en_nxt;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               beat;
  logic               hold_done;
  logic [WIDTH-1:0]   mux_data;

  rr_priority_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  // A beat moves only while granted, the owner has data and downstream accepts.
  assign beat      = en && req[select] && out_ready;
  assign hold_done = (cnt == CNT_W'(HOLD_MAX - 1));

  // Control registers: all state is reset; there is no registered data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      grant  <= '0;
      select <= '0;
      en     <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      cnt    <= cnt_nxt;
      grant  <= grant_nxt;
      select <= select_nxt;
      en     <= en_nxt;
    end
  end

  // Next-state: arbitrate from IDLE, release on last beat, hold limit or abandon.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    cnt_nxt    = cnt;
    grant_nxt  = grant;
    select_nxt = select;
    en_nxt     = en;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt  = GRANT;
          grant_nxt  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          select_nxt = pick_idx;
          en_nxt     = 1'b1;
          cnt_nxt    = '0;
        end
      end
      GRANT: begin
        if (!req[select] || (beat && (last[select] || hold_done))) begin
          state_nxt = IDLE;
          ptr_nxt   = select + SEL_W'(1);
          grant_nxt = '0;
          en_nxt    = 1'b0;
          cnt_nxt   = '0;
        end else if (beat) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // 8:1 datapath mux on the registered select, using constant slices only.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (select == SEL_W'(i)) begin
        mux_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Boundary outputs: everything forced to zero while the mux is disabled.
  always_comb begin
    in_ready  = '0;
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    if (en) begin
      in_ready[select] = out_ready;
      out_data         = mux_data;
      out_valid        = req[select];
      out_last         = last[select];
    end
  end

endmodule
